// File: rtl/imem_fetch_unit.sv
// Instruction store: self-clears to NOP after reset, then serves one registered fetch per cycle (1-cycle latency).
// req_ready drops while a load is in progress or a held response is not yet consumed, so the output register never overflows.
module imem_fetch_unit #(
    parameter int                   ADDR_LEN  = 32,
    parameter int                   INSTR_LEN = 32,
    parameter int                   DEPTH     = 1024,
    parameter logic [INSTR_LEN-1:0] NOP       = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_LEN-1:0]        req_addr,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [INSTR_LEN-1:0]       rsp_instr,
    output logic [ADDR_LEN-1:0]        rsp_addr,
    output logic [1:0]                 rsp_fault,
    input  logic                       ld_en,
    input  logic [$clog2(DEPTH)-1:0]   ld_addr,
    input  logic [INSTR_LEN-1:0]       ld_data,
    output logic                       busy
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int WIDX_W = ADDR_LEN - 2;
    // One extra bit so DEPTH itself is representable even when it fills the address space.
    localparam logic [WIDX_W:0] DEPTH_LIM = (WIDX_W + 1)'(DEPTH);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      clr_cnt_q, clr_cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [INSTR_LEN-1:0]  rsp_instr_q, rsp_instr_d;
    logic [ADDR_LEN-1:0]   rsp_addr_q, rsp_addr_d;
    logic [1:0]            rsp_fault_q, rsp_fault_d;

    logic [INSTR_LEN-1:0]  mem_q [DEPTH];
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_waddr;
    logic [INSTR_LEN-1:0]  mem_wdata;

    logic [WIDX_W-1:0]     word_idx;
    logic                  fault_misal;
    logic                  fault_oor;
    logic                  accept;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_instr_d = rsp_instr_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_fault_d = rsp_fault_q;
        mem_we      = 1'b0;
        mem_waddr   = ld_addr;
        mem_wdata   = ld_data;
        busy        = 1'b0;
        req_ready   = 1'b0;

        if (state_q == CLEAR) begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = NOP;
            clr_cnt_d = clr_cnt_q + IDX_W'(1);
            if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end else begin
            mem_we    = ld_en;
            req_ready = !ld_en && (!rsp_valid_q || rsp_ready);
        end

        // Range check uses every upper address bit so high addresses never alias into the array.
        word_idx    = req_addr[ADDR_LEN-1:2];
        fault_misal = (req_addr[1:0] != 2'b00);
        fault_oor   = ({1'b0, word_idx} >= DEPTH_LIM);
        accept      = req_valid && req_ready;

        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_addr_d  = req_addr;
            rsp_fault_d = {fault_oor, fault_misal};
            rsp_instr_d = (fault_misal || fault_oor) ? NOP : mem_q[word_idx[IDX_W-1:0]];
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= NOP;
            rsp_addr_q  <= '0;
            rsp_fault_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_instr = rsp_instr_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit with DEPTH=16: directed scenarios followed by randomized traffic.
module tb_imem_fetch_unit;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_fault;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic        busy;

    always #5 clk = ~clk;

    imem_fetch_unit #(
        .ADDR_LEN (32),
        .INSTR_LEN(32),
        .DEPTH    (DEPTH),
        .NOP      (32'h0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr),
        .rsp_addr (rsp_addr),
        .rsp_fault(rsp_fault),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .busy     (busy)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [1:0]  fault;
    } rsp_t;

    rsp_t        sb_q[$];
    logic [31:0] model_mem [DEPTH];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    bit          prev_rst = 1'b1;
    int          busy_left = 15;
    bit          exp_busy;
    bit          exp_rr;
    bit          acc = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, required 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Reference: word = addr/4; misaligned if addr%4 != 0; out of range if word >= DEPTH.
    function automatic rsp_t predict(input logic [31:0] a);
        rsp_t        r;
        logic [31:0] w;
        w       = a >> 2;
        r.addr  = a;
        r.fault = {(w >= 32'(DEPTH)), (a % 4 != 0)};
        r.instr = (r.fault != 2'b00) ? 32'h0 : model_mem[w];
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_rst) begin
                exp_busy = 1'b1;
                chk("reset_rsp_instr", rsp_instr, 32'h0);
                chk("reset_rsp_addr", rsp_addr, 32'h0);
                chk("reset_rsp_fault", 32'(rsp_fault), 32'h0);
            end else begin
                exp_busy = (busy_left > 0);
                if (busy_left > 0) busy_left--;
            end
            chk("busy", 32'(busy), 32'(exp_busy));
            exp_rr = !exp_busy && !ld_en && (sb_q.size() == 0 || rsp_ready);
            chk("req_ready", 32'(req_ready), 32'(exp_rr));
            chk("rsp_valid", 32'(rsp_valid), 32'(sb_q.size() != 0));
            if (rsp_valid && sb_q.size() != 0) begin
                chk("rsp_instr", rsp_instr, sb_q[0].instr);
                chk("rsp_addr", rsp_addr, sb_q[0].addr);
                chk("rsp_fault", 32'(rsp_fault), 32'(sb_q[0].fault));
            end

            if (rst) begin
                sb_q.delete();
                for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
                busy_left = 15;
                prev_rst  = 1'b1;
            end else begin
                prev_rst = 1'b0;
                if (sb_q.size() != 0 && rsp_ready) void'(sb_q.pop_front());
                if (req_valid && req_ready) sb_q.push_back(predict(req_addr));
                if (ld_en && !exp_busy) model_mem[ld_addr] = ld_data;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        bit got;
        int n;
        req_valid = 1'b1;
        req_addr  = a;
        got       = 1'b0;
        n         = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL fetch_accept addr 0x%0h: not accepted after %0d cycles, required acceptance", a, n);
        end
        req_valid = 1'b0;
    endtask

    task automatic load(input logic [3:0] idx, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = idx;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        case ($urandom_range(0, 7))
            0:       r = $urandom;
            1:       r = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            2:       r = 32'($urandom_range(16, 40)) << 2;
            default: r = 32'($urandom_range(0, 15)) << 2;
        endcase
        return r;
    endfunction

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        rsp_ready = 1'b1;
        ld_en     = 1'b0;
        ld_addr   = 4'h0;
        ld_data   = 32'h0;
        @(posedge clk);
        mon_en = 1'b1;
        #1;
        rst = 1'b0;

        // Clear sequence, then a fetch of the last word.
        idle(20);
        fetch(32'h3C);
        idle(2);

        // Load and back-to-back stream.
        load(4'd0, 32'h11111111);
        load(4'd1, 32'h22222222);
        load(4'd2, 32'h33333333);
        load(4'd3, 32'h44444444);
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        fetch(32'hC);
        idle(2);

        // Back-pressure with a queued request.
        rsp_ready = 1'b0;
        fetch(32'h4);
        req_valid = 1'b1;
        req_addr  = 32'h8;
        idle(3);
        rsp_ready = 1'b1;
        fetch(32'h8);
        idle(2);

        // Fault encodings.
        fetch(32'h6);
        fetch(32'h40);
        fetch(32'h42);
        fetch(32'h100000);
        idle(2);

        // Load and fetch in the same cycle.
        ld_en     = 1'b1;
        ld_addr   = 4'd2;
        ld_data   = 32'hDEADBEEF;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        fetch(32'h8);
        idle(2);

        // Randomized traffic; a pending request is held until accepted.
        for (int i = 0; i < 400; i++) begin
            if (!req_valid || acc) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_addr  = rand_addr();
            end
            ld_en     = ($urandom_range(0, 4) == 0);
            ld_addr   = 4'($urandom_range(0, 15));
            ld_data   = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = req_valid && req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        ld_en     = 1'b0;
        rsp_ready = 1'b1;
        idle(3);

        // Reset while a response is stalled.
        load(4'd0, 32'h12345678);
        rsp_ready = 1'b0;
        fetch(32'h0);
        idle(1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(20);
        rsp_ready = 1'b1;
        fetch(32'h0);
        idle(3);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
